// File: rtl/board_clear_ctl.sv
// ---------------------------------------------------------------------------
// board_clear_ctl
//
// Line-clear pass controller for a 10 x 20 playfield held in an external
// synchronous row RAM. After the piece controller locks a piece it pulses
// `start`. The block then walks the board bottom (row 19) to top (row 0).
// It reads each row and rewrites every non-full row at a separate write
// pointer. Full rows are therefore squeezed out and the surviving rows
// stay in their original order, packed toward row 19. The rows left
// vacant at the top are then zero-filled, and `done` pulses for one cycle.
//
// Ports
//   pclk       in   1   pixel clock, rising edge
//   rst        in   1   synchronous active-high reset
//   start      in   1   one-cycle request for a pass (ignored while busy)
//   row_rdata  in  10   row contents, valid the cycle after rd_addr
//   rd_addr    out  5   row read address (0 = top, 19 = bottom)
//   wr_addr    out  5   row write address
//   row_we     out  1   row write enable
//   row_wdata  out 10   row write data
//   busy       out  1   pass in progress
//   done       out  1   one-cycle end-of-pass pulse
//   lines      out  3   full rows removed by the last pass (saturates at 7)
//   score_add  out 11   points for the last pass
//
// Build option
//   SCORE_EN   when defined, score_add carries 0/40/100/300/1200 points for
//              0/1/2/3/4+ lines. When undefined, score_add is tied to 0 and
//              no scoring logic exists.
// ---------------------------------------------------------------------------
module board_clear_ctl (
    input  logic        pclk,
    input  logic        rst,
    input  logic        start,
    input  logic [9:0]  row_rdata,
    output logic [4:0]  rd_addr,
    output logic [4:0]  wr_addr,
    output logic        row_we,
    output logic [9:0]  row_wdata,
    output logic        busy,
    output logic        done,
    output logic [2:0]  lines,
    output logic [10:0] score_add
);

    localparam logic [4:0] LAST_ROW = 5'd19;
    localparam logic [9:0] FULL_ROW = 10'h3FF;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        EVAL,
        FILL,
        DONE
    } state_t;

    state_t     state;
    logic [4:0] rd_ptr;
    logic [4:0] wr_ptr;
    logic [2:0] fill_cnt;

    logic       row_full;
    logic [2:0] lines_inc;
    logic [2:0] lines_eval;
    logic [2:0] fill_next;
    logic       last_fill;

    // Row data only arrives during EVAL, so the full-row test and the
    // write-back path are decoded from the registered state.
    always_comb begin
        row_full   = (row_rdata == FULL_ROW);
        lines_inc  = (lines == 3'd7) ? 3'd7 : lines + 3'd1;
        lines_eval = row_full ? lines_inc : lines;
        fill_next  = fill_cnt + 3'd1;
        last_fill  = (fill_next == lines);
    end

    // The write port copies row_rdata straight through in EVAL, because the
    // data is only valid in that cycle. In every other state it is quiet.
    always_comb begin
        row_we    = 1'b0;
        row_wdata = 10'd0;
        case (state)
            EVAL: begin
                if (!row_full) begin
                    row_we    = 1'b1;
                    row_wdata = row_rdata;
                end
            end
            FILL: begin
                row_we    = 1'b1;
                row_wdata = 10'd0;
            end
            default: begin
                row_we    = 1'b0;
                row_wdata = 10'd0;
            end
        endcase
    end

    assign wr_addr = wr_ptr;

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= IDLE;
            rd_ptr   <= 5'd0;
            wr_ptr   <= 5'd0;
            fill_cnt <= 3'd0;
            lines    <= 3'd0;
            rd_addr  <= 5'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rd_ptr   <= LAST_ROW;
                        wr_ptr   <= LAST_ROW;
                        fill_cnt <= 3'd0;
                        lines    <= 3'd0;
                        // rd_addr is registered, so the address is set up
                        // on entry to RD. That way the RAM sees it for the
                        // whole RD cycle.
                        rd_addr  <= LAST_ROW;
                        busy     <= 1'b1;
                        state    <= RD;
                    end
                end

                RD: begin
                    state <= EVAL;
                end

                EVAL: begin
                    lines <= lines_eval;
                    if (!row_full && (wr_ptr != 5'd0)) begin
                        wr_ptr <= wr_ptr - 5'd1;
                    end
                    if (rd_ptr == 5'd0) begin
                        if (lines_eval != 3'd0) begin
                            state <= FILL;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        rd_ptr  <= rd_ptr - 5'd1;
                        rd_addr <= rd_ptr - 5'd1;
                        state   <= RD;
                    end
                end

                FILL: begin
                    if (wr_ptr != 5'd0) begin
                        wr_ptr <= wr_ptr - 5'd1;
                    end
                    fill_cnt <= fill_next;
                    if (last_fill) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SCORE_EN
    function automatic logic [10:0] score_of(input logic [2:0] n);
        case (n)
            3'd0:    score_of = 11'd0;
            3'd1:    score_of = 11'd40;
            3'd2:    score_of = 11'd100;
            3'd3:    score_of = 11'd300;
            default: score_of = 11'd1200;
        endcase
    endfunction

    // A zero-line pass goes straight from EVAL to DONE, and the score was
    // already cleared at start. So only the last FILL cycle has to load a
    // new value.
    always_ff @(posedge pclk) begin
        if (rst) begin
            score_add <= 11'd0;
        end else if ((state == IDLE) && start) begin
            score_add <= 11'd0;
        end else if ((state == FILL) && last_fill) begin
            score_add <= score_of(lines);
        end
    end
`else
    assign score_add = 11'd0;
`endif

endmodule

// File: tb/tb_board_clear_ctl.sv
module tb_board_clear_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic [9:0]  row_rdata;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic        row_we;
    logic [9:0]  row_wdata;
    logic        busy;
    logic        done;
    logic [2:0]  lines;
    logic [10:0] score_add;

    board_clear_ctl dut (
        .pclk      (pclk),
        .rst       (rst),
        .start     (start),
        .row_rdata (row_rdata),
        .rd_addr   (rd_addr),
        .wr_addr   (wr_addr),
        .row_we    (row_we),
        .row_wdata (row_wdata),
        .busy      (busy),
        .done      (done),
        .lines     (lines),
        .score_add (score_add)
    );

    always #5 pclk = ~pclk;

    // Board RAM: synchronous read, write on the rising edge.
    logic [9:0] mem [0:19];
    int         wr_count;
    int         done_count;

    initial row_rdata = 10'd0;

    always @(posedge pclk) begin
        row_rdata <= mem[rd_addr];
        if (row_we) begin
            mem[wr_addr] = row_wdata;
            wr_count     = wr_count + 1;
        end
        if (done) done_count = done_count + 1;
    end

    typedef struct packed {
        logic [2:0]   lines;
        logic [10:0]  score;
        logic [7:0]   latency;
        logic [199:0] board;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [10:0] exp_score(input int n);
`ifdef SCORE_EN
        if (n == 0) return 11'd0;
        if (n == 1) return 11'd40;
        if (n == 2) return 11'd100;
        if (n == 3) return 11'd300;
        return 11'd1200;
`else
        return 11'd0;
`endif
    endfunction

    function automatic logic [199:0] pack_board();
        logic [199:0] b;
        b = '0;
        for (int r = 0; r < 20; r++) b[r*10 +: 10] = mem[r];
        return b;
    endfunction

    // Reference: keep non-full rows in order, packed at the bottom, zeros above.
    function automatic exp_t model();
        exp_t       e;
        logic [9:0] kept [$];
        int         n;
        for (int r = 19; r >= 0; r--) if (mem[r] != 10'h3FF) kept.push_back(mem[r]);
        n         = 20 - kept.size();
        e.board   = '0;
        for (int i = 0; i < kept.size(); i++) e.board[(19-i)*10 +: 10] = kept[i];
        e.lines   = 3'(n);
        e.score   = exp_score(n);
        e.latency = 8'(40 + n);
        return e;
    endfunction

    task automatic clear_board();
        for (int r = 0; r < 20; r++) mem[r] = 10'd0;
    endtask

    task automatic run_pass(input string name, input int repulse_at);
        exp_t e;
        int   edges;
        bit   got;
        exp_q.push_back(model());
        wr_count   = 0;
        done_count = 0;
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        chk({name, "_busy"}, 200'(busy), 200'(1'b1));
        edges = 0;
        got   = 0;
        while (edges < 100 && !got) begin
            if (edges + 1 == repulse_at) start = 1'b1;
            @(posedge pclk); #1;
            start = 1'b0;
            edges++;
            if (done) got = 1;
        end
        chk({name, "_done_seen"}, 200'(got), 200'(1'b1));
        e = exp_q.pop_front();
        chk({name, "_latency"}, 200'(edges), 200'(e.latency));
        chk({name, "_lines"}, 200'(lines), 200'(e.lines));
        chk({name, "_score"}, 200'(score_add), 200'(e.score));
        @(posedge pclk); #1;
        chk({name, "_done_pulse"}, 200'(done), 200'(1'b0));
        chk({name, "_idle"}, 200'(busy), 200'(1'b0));
        repeat (3) @(posedge pclk);
        #1;
        chk({name, "_done_count"}, 200'(done_count), 200'(1));
        chk({name, "_lines_held"}, 200'(lines), 200'(e.lines));
        chk({name, "_writes"}, 200'(wr_count), 200'(20));
        chk({name, "_rd_hold"}, 200'(rd_addr), 200'(5'd0));
        chk({name, "_board"}, pack_board(), e.board);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        wr_count   = 0;
        done_count = 0;
        clear_board();
        repeat (3) @(posedge pclk);
        #1;
        chk("rst_busy", 200'(busy), 200'(1'b0));
        chk("rst_done", 200'(done), 200'(1'b0));
        chk("rst_we", 200'(row_we), 200'(1'b0));
        chk("rst_lines", 200'(lines), 200'(3'd0));
        chk("rst_score", 200'(score_add), 200'(11'd0));
        chk("rst_rd_addr", 200'(rd_addr), 200'(5'd0));
        chk("rst_wr_addr", 200'(wr_addr), 200'(5'd0));
        chk("rst_wdata", 200'(row_wdata), 200'(10'd0));
        rst = 1'b0;
        @(posedge pclk); #1;

        // Empty board
        clear_board();
        run_pass("empty", 0);

        // Row 19 full; non-zero marker rows check ordering
        clear_board();
        mem[19] = 10'h3FF;
        mem[18] = 10'h0AA;
        mem[10] = 10'h201;
        run_pass("one_line", 0);

        // Rows 16..19 full, row 15 = 155
        clear_board();
        for (int r = 16; r < 20; r++) mem[r] = 10'h3FF;
        mem[15] = 10'h155;
        run_pass("four_lines", 0);

        // Rows 17 and 19 full, row 18 = 001
        clear_board();
        mem[19] = 10'h3FF;
        mem[17] = 10'h3FF;
        mem[18] = 10'h001;
        mem[16] = 10'h2F0;
        run_pass("split_two", 0);

        // Three scattered full rows, start re-pulsed at edge 10
        clear_board();
        for (int r = 0; r < 20; r++) mem[r] = 10'(r + 1);
        mem[3]  = 10'h3FF;
        mem[11] = 10'h3FF;
        mem[0]  = 10'h3FF;
        run_pass("repulse", 10);

        // Reset at edge 20 of a pass
        clear_board();
        mem[19] = 10'h3FF;
        done_count = 0;
        start = 1'b1;
        @(posedge pclk); #1;
        start = 1'b0;
        repeat (19) @(posedge pclk);
        #1;
        rst = 1'b1;
        @(posedge pclk); #1;
        rst = 1'b0;
        chk("abort_busy", 200'(busy), 200'(1'b0));
        chk("abort_we", 200'(row_we), 200'(1'b0));
        chk("abort_lines", 200'(lines), 200'(3'd0));
        wr_count = 0;
        repeat (60) @(posedge pclk);
        #1;
        chk("abort_no_done", 200'(done_count), 200'(0));
        chk("abort_no_writes", 200'(wr_count), 200'(0));
        chk("abort_still_idle", 200'(busy), 200'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
